// File: rtl/store_steer_buffer_if.sv
// Pipeline-store and data-memory bus bundle for store_steer_buffer.
// The slave modport is the buffer's view; the master modport is the pipeline/memory side.
interface store_steer_buffer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_data;
   logic [2:0]  in_funct3;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;

   modport slave (
      input  in_valid, in_addr, in_data, in_funct3, mem_ack,
      output in_ready, mem_req, mem_addr, mem_wdata, mem_be
   );

   modport master (
      output in_valid, in_addr, in_data, in_funct3, mem_ack,
      input  in_ready, mem_req, mem_addr, mem_wdata, mem_be
   );
endinterface

// File: rtl/store_steer_buffer.sv
// Store byte-lane steering plus a DEPTH-entry FIFO store buffer feeding a req/ack memory bus.
// Define STORE_MERGE_EN to let a legal store merge into a same-word tail entry.
module store_steer_buffer #(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   store_steer_buffer_if.slave      bus,
   output logic                     misaligned,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [29:0]   addr_q  [DEPTH];
   logic [31:0]   wdata_q [DEPTH];
   logic [3:0]    be_q    [DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          mis_q, mis_d;

   logic          legal_s, full_s, take_s, pop_s, enq_s, merge_hit_s;
   logic [31:0]   wdata_s;
   logic [3:0]    be_s;

   // Legality check and lane steering of the incoming store
   always_comb begin
      legal_s = 1'b0;
      wdata_s = 32'h0000_0000;
      be_s    = 4'b0000;
      case (bus.in_funct3)
         3'b000: begin
            legal_s = 1'b1;
            wdata_s = {4{bus.in_data[7:0]}};
            be_s    = 4'b0001 << bus.in_addr[1:0];
         end
         3'b001: begin
            legal_s = ~bus.in_addr[0];
            wdata_s = {2{bus.in_data[15:0]}};
            be_s    = bus.in_addr[1] ? 4'b1100 : 4'b0011;
         end
         3'b010: begin
            legal_s = (bus.in_addr[1:0] == 2'b00);
            wdata_s = bus.in_data;
            be_s    = 4'b1111;
         end
         default: begin
            legal_s = 1'b0;
         end
      endcase
   end

`ifdef STORE_MERGE_EN
   logic [AW-1:0] tail_m1_s;
   assign tail_m1_s = tail_q - PTR_ONE;

   // With two or more entries the tail is never the head, so a pop cannot hit it
   always_comb begin
      if (legal_s && (count_q >= CW'(2)) && (addr_q[tail_m1_s] == bus.in_addr[31:2])) begin
         merge_hit_s = 1'b1;
      end else begin
         merge_hit_s = 1'b0;
      end
   end
`else
   assign merge_hit_s = 1'b0;
`endif

   assign full_s       = (count_q == CNT_FULL);
   assign bus.in_ready = ~full_s | merge_hit_s;
   assign take_s       = bus.in_valid & bus.in_ready;
   assign pop_s        = bus.mem_ack & (count_q != CNT_ZERO);
   assign enq_s        = take_s & legal_s & ~merge_hit_s;

   // Next-state for pointers, occupancy and the misaligned pulse
   always_comb begin
      mis_d  = take_s & ~legal_s;
      head_d = pop_s ? head_q + PTR_ONE : head_q;
      tail_d = enq_s ? tail_q + PTR_ONE : tail_q;
      if (enq_s && !pop_s) begin
         count_d = count_q + CNT_ONE;
      end else if (!enq_s && pop_s) begin
         count_d = count_q - CNT_ONE;
      end else begin
         count_d = count_q;
      end
   end

   // Control state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= CNT_ZERO;
         mis_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         mis_q   <= mis_d;
      end
   end

   // Entry storage: enqueue at tail, or lane-merge into the previous tail
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i]  <= 30'h0;
            wdata_q[i] <= 32'h0000_0000;
            be_q[i]    <= 4'b0000;
         end
      end else if (enq_s) begin
         addr_q[tail_q]  <= bus.in_addr[31:2];
         wdata_q[tail_q] <= wdata_s;
         be_q[tail_q]    <= be_s;
`ifdef STORE_MERGE_EN
      end else if (take_s && merge_hit_s) begin
         for (int l = 0; l < 4; l++) begin
            if (be_s[l]) begin
               wdata_q[tail_m1_s][8*l +: 8] <= wdata_s[8*l +: 8];
            end
         end
         be_q[tail_m1_s] <= be_q[tail_m1_s] | be_s;
`endif
      end
   end

   assign bus.mem_req   = (count_q != CNT_ZERO);
   assign bus.mem_addr  = {addr_q[head_q], 2'b00};
   assign bus.mem_wdata = wdata_q[head_q];
   assign bus.mem_be    = be_q[head_q];
   assign misaligned    = mis_q;
   assign count         = count_q;
   assign empty         = (count_q == CNT_ZERO);
endmodule

// File: tb/tb_store_steer_buffer.sv
// Self-checking bench for store_steer_buffer: steering table, FIFO scoreboard, full/reset/merge corners.
module tb_store_steer_buffer;
   logic       clk = 1'b0;
   logic       reset;
   logic       misaligned;
   logic [1:0] count;
   logic       empty;

   store_steer_buffer_if bus ();

   store_steer_buffer #(.DEPTH(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .misaligned (misaligned),
      .count      (count),
      .empty      (empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  f3;
      logic        legal;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [3:0]  e_be;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } txn_t;

   txn_t sb[$];
   vec_t vecs[11];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       input logic push, input logic [31:0] ea, input logic [31:0] ew,
                       input logic [3:0] eb);
      txn_t t;
      bus.in_valid  = 1'b1;
      bus.in_addr   = a;
      bus.in_data   = d;
      bus.in_funct3 = f;
      #1;
      check("send_in_ready", 32'(bus.in_ready), 32'd1);
      if (push) begin
         t.addr = ea; t.wdata = ew; t.be = eb;
         sb.push_back(t);
      end
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic ack_head();
      txn_t t;
      check("ack_mem_req", 32'(bus.mem_req), 32'd1);
      if (sb.size() == 0) begin
         check("ack_sb_nonempty", 32'd0, 32'd1);
      end else begin
         t = sb.pop_front();
         check("ack_mem_addr",  bus.mem_addr,       t.addr);
         check("ack_mem_wdata", bus.mem_wdata,      t.wdata);
         check("ack_mem_be",    32'(bus.mem_be),    32'(t.be));
      end
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111};
      vecs[1]  = '{32'h0000_0203, 32'h0000_00A5, 3'b000, 1'b1, 32'h0000_0200, 32'hA5A5_A5A5, 4'b1000};
      vecs[2]  = '{32'h0000_0202, 32'h0000_1234, 3'b001, 1'b1, 32'h0000_0200, 32'h1234_1234, 4'b1100};
      vecs[3]  = '{32'h0000_0101, 32'h1234_5677, 3'b000, 1'b1, 32'h0000_0100, 32'h7777_7777, 4'b0010};
      vecs[4]  = '{32'h0000_0100, 32'hABCD_BEEF, 3'b001, 1'b1, 32'h0000_0100, 32'hBEEF_BEEF, 4'b0011};
      vecs[5]  = '{32'h7FFF_FFFE, 32'h0000_005A, 3'b000, 1'b1, 32'h7FFF_FFFC, 32'h5A5A_5A5A, 4'b0100};
      vecs[6]  = '{32'h0000_0101, 32'h0000_1234, 3'b001, 1'b0, 32'h0, 32'h0, 4'b0000};
      vecs[7]  = '{32'h0000_0102, 32'h1111_2222, 3'b010, 1'b0, 32'h0, 32'h0, 4'b0000};
      vecs[8]  = '{32'h0000_0100, 32'h1111_2222, 3'b011, 1'b0, 32'h0, 32'h0, 4'b0000};
      vecs[9]  = '{32'h0000_0100, 32'h1111_2222, 3'b100, 1'b0, 32'h0, 32'h0, 4'b0000};
      vecs[10] = '{32'h0000_0203, 32'h1111_2222, 3'b111, 1'b0, 32'h0, 32'h0, 4'b0000};

      reset = 1'b1;
      bus.in_valid = 1'b0; bus.in_addr = 32'h0; bus.in_data = 32'h0;
      bus.in_funct3 = 3'b000; bus.mem_ack = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      check("rst_count",    32'(count),          32'd0);
      check("rst_empty",    32'(empty),          32'd1);
      check("rst_mem_req",  32'(bus.mem_req),    32'd0);
      check("rst_mis",      32'(misaligned),     32'd0);
      check("rst_mem_addr", bus.mem_addr,        32'h0);
      check("rst_wdata",    bus.mem_wdata,       32'h0);
      check("rst_be",       32'(bus.mem_be),     32'd0);
      check("rst_in_ready", 32'(bus.in_ready),   32'd1);

      // SW held on the bus without ack: fields must stay put
      send(32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111);
      for (int c = 0; c < 5; c++) begin
         check("hold_req",   32'(bus.mem_req), 32'd1);
         check("hold_addr",  bus.mem_addr,     32'h0000_0100);
         check("hold_wdata", bus.mem_wdata,    32'hDEAD_BEEF);
         check("hold_be",    32'(bus.mem_be),  32'hF);
         tick();
      end
      ack_head();
      check("hold_empty_after", 32'(empty), 32'd1);
      check("hold_req_after",   32'(bus.mem_req), 32'd0);

      // Steering / legality table
      for (int i = 0; i < 11; i++) begin
         send(vecs[i].addr, vecs[i].data, vecs[i].f3, vecs[i].legal,
              vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_be);
         if (vecs[i].legal) begin
            check("vec_mis0",  32'(misaligned), 32'd0);
            check("vec_count", 32'(count),      32'd1);
            ack_head();
            check("vec_drained", 32'(count), 32'd0);
         end else begin
            check("vec_mis1",    32'(misaligned),  32'd1);
            check("vec_cnt0",    32'(count),       32'd0);
            check("vec_req0",    32'(bus.mem_req), 32'd0);
            tick();
            check("vec_mis_end", 32'(misaligned),  32'd0);
         end
      end

      // Full buffer: third store stalls, ack does not free a slot the same edge
      send(32'h0000_0500, 32'h0000_0001, 3'b010, 1'b1, 32'h0000_0500, 32'h0000_0001, 4'hF);
      send(32'h0000_0504, 32'h0000_0002, 3'b010, 1'b1, 32'h0000_0504, 32'h0000_0002, 4'hF);
      bus.in_valid = 1'b1; bus.in_addr = 32'h0000_0508;
      bus.in_data = 32'h0000_0003; bus.in_funct3 = 3'b010;
      #1;
      check("full_ready0", 32'(bus.in_ready), 32'd0);
      check("full_count",  32'(count),        32'd2);
      ack_head();
      check("full_count_after_ack", 32'(count), 32'd1);
      check("full_ready1", 32'(bus.in_ready), 32'd1);
      sb.push_back('{32'h0000_0508, 32'h0000_0003, 4'hF});
      tick();
      bus.in_valid = 1'b0;
      check("full_count_after_enq", 32'(count), 32'd2);
      ack_head();
      ack_head();
      check("full_drained_empty", 32'(empty), 32'd1);
      check("full_sb_empty", 32'(sb.size()), 32'd0);

      // Reset during an ack cycle discards everything
      send(32'h0000_0600, 32'hAAAA_AAAA, 3'b010, 1'b0, 32'h0, 32'h0, 4'h0);
      send(32'h0000_0604, 32'hBBBB_BBBB, 3'b010, 1'b0, 32'h0, 32'h0, 4'h0);
      bus.mem_ack = 1'b1; reset = 1'b1;
      tick();
      bus.mem_ack = 1'b0; reset = 1'b0;
      check("mrst_count", 32'(count),       32'd0);
      check("mrst_req",   32'(bus.mem_req), 32'd0);
      repeat (3) tick();
      check("mrst_req_later", 32'(bus.mem_req), 32'd0);
      check("mrst_empty",     32'(empty),       32'd1);

`ifdef STORE_MERGE_EN
      // Merge into the tail while full
      send(32'h0000_0300, 32'h1122_3344, 3'b010, 1'b1, 32'h0000_0300, 32'h1122_3344, 4'hF);
      send(32'h0000_0400, 32'h0000_0000, 3'b010, 1'b1, 32'h0000_0400, 32'hFF00_0000, 4'hF);
      send(32'h0000_0403, 32'h0000_00FF, 3'b000, 1'b0, 32'h0, 32'h0, 4'h0);
      check("merge_count", 32'(count),      32'd2);
      check("merge_mis",   32'(misaligned), 32'd0);
      ack_head();
      ack_head();
      check("merge_empty", 32'(empty), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule

// File: doc/store_steer_buffer.md
Name: store_steer_buffer

Overview:
- Store-side byte-lane steering unit plus a small store buffer, placed between the MEM stage and the data-memory bus.
- Takes a store (address, rs2 data, funct3) from the pipeline and steers the byte or halfword onto the correct lanes with byte enables.
- Queues up to DEPTH stores and presents them one at a time to memory with a req/ack handshake.
- Back-pressures the pipeline through in_ready when full.

Parameters:
- DEPTH, 2, number of buffered stores; power of two, at least 2.

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  synchronous reset, active-high
- in_valid  input  1  MEM stage presents a store this cycle
- in_ready  output  1  buffer can accept; equals !full
- in_addr  input  32  byte address of store
- in_data  input  32  rs2 value, unsteered
- in_funct3  input  3  000=SB, 001=SH, 010=SW; any other value is illegal
- mem_req  output  1  head entry valid on bus
- mem_addr  output  32  head word address, bits [1:0] always 00
- mem_wdata  output  32  head steered data
- mem_be  output  4  head byte enables
- mem_ack  input  1  memory accepts head this cycle
- misaligned  output  1  one-cycle pulse: last accepted-handshake store was rejected
- count  output  $clog2(DEPTH)+1  number of occupied entries
- empty  output  1  count==0

Behaviour:
- Reset: buffer cleared; pointers=0; count=0; empty=1; mem_req=0; misaligned=0; mem_addr/mem_wdata/mem_be=0.
- Reset mid-transfer: the pending store is discarded, not retried. mem_ack in the reset cycle is ignored.
- Handshake: a store transfers on an edge where in_valid && in_ready. in_ready = (count != DEPTH).
- No bypass: when full, a simultaneous mem_ack does not free a slot for the same edge. in_ready stays 0 that cycle.
- Legality check at transfer:
  - SH with addr[0]=1 is illegal.
  - SW with addr[1:0]!=0 is illegal.
  - Any funct3 outside {000,001,010} is illegal.
- Illegal stores are consumed, not enqueued. misaligned=1 for exactly the next cycle. count is unchanged.
- Steering, written at enqueue:
  - SB: wdata = {4{data[7:0]}}; be = 4'b0001 << addr[1:0].
  - SH: wdata = {2{data[15:0]}}; be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata = data; be = 4'b1111.
  - Stored address = {addr[31:2],2'b00}.
- Latency: a store enqueued into an empty buffer at edge N drives mem_req=1 with its fields from just after edge N. No combinational in->mem path.
- Bus rules:
  - mem_req=1 iff count>0.
  - mem_addr/mem_wdata/mem_be hold stable while mem_req=1 and mem_ack=0.
  - mem_ack with mem_req=1 pops the head at that edge. If entries remain, the next entry is presented the following cycle with mem_req staying high.
  - mem_ack with mem_req=0 is ignored.
- Simultaneous enqueue and pop (not full): count unchanged; the new entry goes to the tail.
- Pointers wrap modulo DEPTH. Order is strictly FIFO.
- count is registered; empty is derived from count.

Optional Feature:
- Macro STORE_MERGE_EN.
- Defined: an incoming legal store merges into the tail entry when all of these hold:
  - count>=2, so the tail is not the head being presented;
  - its word address equals the tail's word address;
  - no pop targets the tail that edge.
- Merge action: per lane, lanes with new be are overwritten; be |= new be; count unchanged.
- Merge is allowed when full: in_ready = !full || merge_hit, where merge_hit is computed combinationally from the inputs.
- Not defined: no merging; every legal store takes a new entry. in_ready = !full.

Test Plan:
- Reset, then SW addr=0x100 data=0xDEADBEEF, mem_ack held 0 -> next cycle mem_req=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, mem_be=1111, all stable for 5 cycles; ack -> empty=1 next cycle.
- SB addr=0x203 data=0x000000A5 -> mem_addr=0x200, mem_wdata=0xA5A5A5A5, mem_be=1000. SH addr=0x202 data=0x1234 -> mem_wdata=0x12341234, mem_be=1100.
- SH addr=0x101, then SW addr=0x102, then funct3=011 -> each gives a misaligned pulse of 1 cycle; count stays 0; mem_req stays 0.
- With mem_ack=0, send 3 legal stores -> third waits with in_ready=0 and count=2. Ack once with in_valid high -> no accept that edge; accepted next edge; memory order preserved.
- Two entries queued, reset asserted during a mem_ack cycle -> next cycle count=0, mem_req=0, and neither store reappears.
- STORE_MERGE_EN: queue SW 0x300=0x11223344, then SW 0x400=0, then SB 0x403 data=0xFF -> count stays 2; second entry mem_wdata=0xFF000000, be=1111.
